// File: rtl/spectrum_peak_detector_pkg.sv
// Shared definitions for the FFT magnitude path: sizing defaults, the detector
// state encoding, IEEE-754 single field constants and the magnitude sanitiser.
package spectrum_peak_detector_pkg;

    localparam int unsigned DEFAULT_SIZE        = 64;
    localparam int unsigned DEFAULT_SEARCH_BINS = DEFAULT_SIZE / 2;

    localparam int unsigned SIGN_BIT = 31;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;

    typedef enum logic {
        StAccum,
        StReport
    } state_t;

    // Negative values and NaNs collapse to +0.0 so that the remaining bits order
    // like an unsigned integer; +Inf survives as the largest legal value.
    function automatic logic [30:0] sanitise(input logic [31:0] v);
        logic is_nan;
        is_nan = (v[30:23] == EXP_MAX) && (v[22:0] != '0);
        if (v[SIGN_BIT] || is_nan) begin
            return '0;
        end
        return v[30:0];
    endfunction

endpackage

// File: rtl/spectrum_peak_detector_fp_mag_compare.sv
// Combinational greater-than between two squared magnitudes, both sanitised
// first so that sign and NaN patterns never win a comparison.
module fp_mag_compare
    import spectrum_peak_detector_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        gt
);

    always_comb begin
        gt = sanitise(a) > sanitise(b);
    end

endmodule

// File: rtl/spectrum_peak_detector.sv
// Per-frame peak search over an FFT magnitude stream: reports the index and value
// of the largest searched bin plus how many searched bins exceed a threshold.
module spectrum_peak_detector
    import spectrum_peak_detector_pkg::*;
#(
    parameter int unsigned SIZE        = DEFAULT_SIZE,
    parameter int unsigned SEARCH_BINS = SIZE / 2,
    parameter bit          SKIP_DC     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mag_valid,
    input  logic [31:0]             mag_data,
    output logic                    mag_ready,
    input  logic [31:0]             threshold,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(SIZE)-1:0] peak_bin,
    output logic [31:0]             peak_mag,
    output logic [$clog2(SIZE):0]   above_cnt,
    output logic [15:0]             frame_cnt
);

    localparam int unsigned IDX_W = $clog2(SIZE);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(SIZE - 1);
    localparam logic [IDX_W-1:0] INIT_IDX   = SKIP_DC ? IDX_W'(1) : '0;
    localparam logic [IDX_W:0]   SEARCH_LIM = (IDX_W + 1)'(SEARCH_BINS);

    state_t             state;
    logic [IDX_W-1:0]   bidx;
    logic [30:0]        run_mag;
    logic [IDX_W-1:0]   run_idx;
    logic [IDX_W:0]     run_cnt;
    logic [31:0]        thr_q;

    logic               xfer;
    logic               searched;
    logic [31:0]        thr_sel;
    logic [30:0]        bin_san;
    logic               bin_gt_peak;
    logic               bin_gt_thr;
    logic [30:0]        nxt_mag;
    logic [IDX_W-1:0]   nxt_idx;
    logic [IDX_W:0]     nxt_cnt;

    assign xfer     = mag_valid && mag_ready;
    assign bin_san  = sanitise(mag_data);
    assign searched = ({1'b0, bidx} < SEARCH_LIM) && !(SKIP_DC && (bidx == '0));
    // Bin 0 compares against the live threshold; later bins use the copy latched with it.
    assign thr_sel  = (bidx == '0) ? threshold : thr_q;

    fp_mag_compare u_peak_cmp (
        .a  (mag_data),
        .b  ({1'b0, run_mag}),
        .gt (bin_gt_peak)
    );

    fp_mag_compare u_thr_cmp (
        .a  (mag_data),
        .b  (thr_sel),
        .gt (bin_gt_thr)
    );

    // Strictly-greater update over ascending indices keeps the lowest index on ties.
    always_comb begin
        nxt_mag = run_mag;
        nxt_idx = run_idx;
        nxt_cnt = run_cnt;
        if (searched) begin
            if (bin_gt_peak) begin
                nxt_mag = bin_san;
                nxt_idx = bidx;
            end
            if (bin_gt_thr) begin
                nxt_cnt = run_cnt + (IDX_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StAccum;
            bidx      <= '0;
            run_mag   <= '0;
            run_idx   <= INIT_IDX;
            run_cnt   <= '0;
            thr_q     <= '0;
            mag_ready <= 1'b0;
            out_valid <= 1'b0;
            peak_bin  <= '0;
            peak_mag  <= '0;
            above_cnt <= '0;
            frame_cnt <= '0;
        end else begin
            case (state)
                StAccum: begin
                    mag_ready <= 1'b1;
                    if (xfer) begin
                        bidx    <= bidx + IDX_W'(1);
                        run_mag <= nxt_mag;
                        run_idx <= nxt_idx;
                        run_cnt <= nxt_cnt;
                        if (bidx == '0) begin
                            thr_q <= threshold;
                        end
                        if (bidx == LAST_IDX) begin
                            state     <= StReport;
                            mag_ready <= 1'b0;
                            out_valid <= 1'b1;
                            peak_bin  <= nxt_idx;
                            peak_mag  <= {1'b0, nxt_mag};
                            above_cnt <= nxt_cnt;
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                    end
                end
                StReport: begin
                    if (out_ready) begin
                        state     <= StAccum;
                        out_valid <= 1'b0;
                        mag_ready <= 1'b1;
                        run_mag   <= '0;
                        run_idx   <= INIT_IDX;
                        run_cnt   <= '0;
                    end
                end
                default: begin
                    state <= StAccum;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spectrum_peak_detector.sv
// Scoreboard bench for spectrum_peak_detector (SIZE=64, SEARCH_BINS=32, SKIP_DC=1):
// expected frame results are queued as frames are driven and compared on out_valid.
module tb_spectrum_peak_detector;

    localparam int SIZE = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mag_valid = 1'b0;
    logic [31:0] mag_data = '0;
    logic        mag_ready;
    logic [31:0] threshold = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  peak_bin;
    logic [31:0] peak_mag;
    logic [6:0]  above_cnt;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    spectrum_peak_detector #(
        .SIZE        (64),
        .SEARCH_BINS (32),
        .SKIP_DC     (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mag_valid (mag_valid),
        .mag_data  (mag_data),
        .mag_ready (mag_ready),
        .threshold (threshold),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .peak_bin  (peak_bin),
        .peak_mag  (peak_mag),
        .above_cnt (above_cnt),
        .frame_cnt (frame_cnt)
    );

    typedef struct packed {
        logic [5:0]  bin;
        logic [31:0] mag;
        logic [6:0]  cnt;
        logic [15:0] fc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] frame[SIZE];
    logic [15:0] exp_fc = '0;
    logic [5:0]  last_bin = '0;
    logic [31:0] last_mag = '0;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] mag_of(input logic [31:0] v);
        if (v[31]) return 32'h0;
        if (v[30:23] == 8'hFF && v[22:0] != 23'h0) return 32'h0;
        return v;
    endfunction

    // Reference: bins 1..31 searched, peak starts at index 1 / value 0.
    function automatic exp_t model(input logic [31:0] thr);
        exp_t        e;
        logic [31:0] t;
        t     = mag_of(thr);
        e.bin = 6'd1;
        e.mag = 32'h0;
        e.cnt = 7'd0;
        for (int k = 1; k < 32; k++) begin
            if (mag_of(frame[k]) > e.mag) begin
                e.mag = mag_of(frame[k]);
                e.bin = 6'(k);
            end
            if (mag_of(frame[k]) > t) e.cnt = e.cnt + 7'd1;
        end
        e.fc = exp_fc;
        return e;
    endfunction

    function automatic logic [31:0] rand_bin();
        logic [31:0] v;
        case ($urandom_range(0, 19))
            0:       v = {1'b1, 31'($urandom)};
            1:       v = 32'h7FC00001;
            2, 3:    v = 32'h42C80000;
            default: v = {1'b0, 8'($urandom_range(100, 140)), 23'($urandom)};
        endcase
        return v;
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the transfer edge.
    task automatic send_bin(input logic [31:0] d, input int gap);
        bit ok;
        ok = 1'b0;
        mag_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        mag_valid = 1'b1;
        mag_data  = d;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = mag_ready;
            @(posedge clk);
            #1;
        end
        mag_valid = 1'b0;
        if (!ok) check("mag_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input logic [31:0] thr, input int max_gap);
        exp_fc = exp_fc + 16'd1;
        sb.push_back(model(thr));
        threshold = thr;
        for (int k = 0; k < SIZE; k++) begin
            send_bin(frame[k], $urandom_range(0, max_gap));
            // Later bins must not see threshold changes.
            if (k == 0) threshold = $urandom;
        end
    endtask

    task automatic collect(input int hold);
        exp_t e;
        bit   seen;
        int   lat;
        seen = 1'b0;
        lat  = 0;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge clk);
            seen = out_valid;
            lat  = t;
        end
        if (!seen) begin
            check("out_valid_timeout", 32'd0, 32'd1);
            return;
        end
        check("latency", 32'(lat), 32'd0);
        if (sb.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check("peak_bin", 32'(peak_bin), 32'(e.bin));
        check("peak_mag", peak_mag, e.mag);
        check("above_cnt", 32'(above_cnt), 32'(e.cnt));
        check("frame_cnt", 32'(frame_cnt), 32'(e.fc));
        last_bin = e.bin;
        last_mag = e.mag;
        if (hold > 0) begin
            @(posedge clk);
            #1;
            mag_valid = 1'b1;
            mag_data  = 32'h7F800000;
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                check("hold_ready", 32'(mag_ready), 32'd0);
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_bin", 32'(peak_bin), 32'(e.bin));
                check("hold_mag", peak_mag, e.mag);
                check("hold_cnt", 32'(above_cnt), 32'(e.cnt));
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        mag_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("ack_valid", 32'(out_valid), 32'd0);
        check("ack_ready", 32'(mag_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        mag_valid = 1'b0;
        out_ready = 1'b0;
        #2;
        check("rst_ready", 32'(mag_ready), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_bin", 32'(peak_bin), 32'd0);
        check("rst_mag", peak_mag, 32'd0);
        check("rst_cnt", 32'(above_cnt), 32'd0);
        check("rst_fc", 32'(frame_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b1;
        exp_fc = '0;
        sb.delete();
        check("rel_ready_low", 32'(mag_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rel_ready_high", 32'(mag_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Single dominant bin with a threshold below only that bin.
        for (int k = 0; k < SIZE; k++) frame[k] = 32'h3F800000;
        frame[5] = 32'h41200000;
        send_frame(32'h40000000, 0);
        collect(0);

        // Tie between bins 3 and 9; +Inf sits in the ignored mirror half.
        for (int k = 0; k < SIZE; k++) frame[k] = 32'h40000000;
        frame[3]  = 32'h42C80000;
        frame[9]  = 32'h42C80000;
        frame[40] = 32'h7F800000;
        send_frame(32'h40000000, 1);
        collect(0);

        // DC excluded; negative bin reads as zero.
        for (int k = 0; k < SIZE; k++) frame[k] = 32'h0;
        frame[0] = 32'h7F800000;
        frame[2] = 32'hC2C80000;
        send_frame(32'h00000000, 0);
        collect(0);

        // Back-pressure on the result.
        for (int k = 0; k < SIZE; k++) frame[k] = {1'b0, 8'(120 + k % 10), 23'(k * 12345)};
        send_frame(32'h3D000000, 0);
        collect(20);

        // Reset mid-frame discards the partial frame.
        for (int k = 0; k < 30; k++) send_bin(32'h47000000, 0);
        @(negedge clk);
        check("accum_bin_stable", 32'(peak_bin), 32'(last_bin));
        check("accum_mag_stable", peak_mag, last_mag);
        check("accum_fc_stable", 32'(frame_cnt), 32'(exp_fc));
        check("accum_valid_low", 32'(out_valid), 32'd0);
        do_reset();
        for (int k = 0; k < SIZE; k++) frame[k] = 32'h3F000000;
        frame[17] = 32'h44000000;
        send_frame(32'h3F400000, 2);
        collect(0);
        check("no_extra_result", 32'(sb.size()), 32'd0);

        // Random frames with random valid gaps.
        do_reset();
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < SIZE; k++) frame[k] = rand_bin();
            send_frame({1'b0, 8'($urandom_range(115, 135)), 23'($urandom)}, 3);
            collect(0);
        end
        check("final_frame_cnt", 32'(frame_cnt), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spectrum_peak_detector.md
SPECTRUM_PEAK_DETECTOR -- requirements
Module: spectrum_peak_detector

Interface
REQ-001 Parameter SIZE, default 64: bins per FFT frame, power of two, 8..1024.
REQ-002 Parameter SEARCH_BINS, default SIZE/2: bins 0..SEARCH_BINS-1 are searched; higher bins are consumed but ignored (real-input mirror).
REQ-003 Parameter SKIP_DC, default 1: when 1, bin 0 is excluded from the peak search and the threshold count.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 mag_valid  input  1  mag_data holds one squared-magnitude bin.
REQ-007 mag_data  input  32  IEEE-754 single, |X[k]|^2, bins in natural order 0..SIZE-1.
REQ-008 mag_ready  output  1  block accepts a bin this cycle.
REQ-009 threshold  input  32  IEEE-754 single, sampled at each frame's bin 0.
REQ-010 out_valid  output  1  frame result available.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 peak_bin  output  log2(SIZE)  index of the largest searched bin.
REQ-013 peak_mag  output  32  value of that bin.
REQ-014 above_cnt  output  log2(SIZE)+1  number of searched bins strictly above threshold.
REQ-015 frame_cnt  output  16  frames completed since reset, wraps 0xFFFF->0.

Function
REQ-016 Transfer of a bin occurs when mag_valid and mag_ready are both 1 on a rising clk edge.
REQ-017 States: ACCUM (mag_ready=1, out_valid=0) and REPORT (mag_ready=0, out_valid=1).
REQ-018 ACCUM: each transfer increments bin index bidx (log2(SIZE) bits); the transfer with bidx=SIZE-1 wraps bidx to 0 and moves to REPORT on the same edge.
REQ-019 REPORT: when out_ready=1, return to ACCUM on that edge and clear the running peak and count. Otherwise hold all outputs stable.
REQ-020 Latency: out_valid rises on the cycle after the last bin's transfer. Earliest next-frame bin 0 is accepted one cycle after the out_ready handshake.
REQ-021 Sanitising: a bin with sign bit 1, or with exponent 0xFF and mantissa non-zero (NaN), is treated as +0.0. +Inf is a legal maximum.
REQ-022 Compare: non-negative floats are compared as 31-bit unsigned integers (bits 30:0). No FP core is used.
REQ-023 Peak update: a searched bin replaces the running peak only if strictly greater. Ties keep the lower index.
REQ-024 The running peak starts each frame at value 0, index 0 (index SKIP_DC if SKIP_DC=1). An all-zero frame reports that index with peak_mag 0.
REQ-025 above_cnt counts searched bins whose sanitised value is strictly greater than the sanitised threshold.
REQ-026 frame_cnt increments on the REPORT-entry edge.
REQ-027 peak_bin, peak_mag and above_cnt are registered and change only on the REPORT-entry edge; they hold their previous values while ACCUM runs.
REQ-028 Gaps in mag_valid are allowed and are not counted. There is no frame-start input; alignment is by count from reset.

Reset
REQ-029 On rst=0, asynchronously: state=ACCUM, bidx=0, running peak and count cleared, out_valid=0, mag_ready=0 while rst is low, peak_bin=0, peak_mag=0, above_cnt=0, frame_cnt=0.
REQ-030 After release, mag_ready=1 from the first clk edge. A frame partially received when reset asserts is discarded.

Structure
REQ-031 A shared package holds SIZE/SEARCH_BINS defaults, the state encoding, the FP field constants (EXP_MAX=8'hFF, SIGN bit 31) and a sanitise function reused by other FFT-path blocks.
REQ-032 One sub-module is used: fp_mag_compare (combinational sanitise plus unsigned greater-than), instantiated twice: peak compare and threshold compare.

Verification
REQ-033 Single 64-bin frame, bin 5 = 0x41200000 (10.0), others 0x3F800000 (1.0), threshold 0x40000000 (2.0) -> out_valid, peak_bin=5, peak_mag=0x41200000, above_cnt=1, frame_cnt=1.
REQ-034 Bins 3 and 9 both = 0x42C80000, the rest smaller -> peak_bin=3. Bin 40 = 0x7F800000 (+Inf, beyond SEARCH_BINS) -> ignored.
REQ-035 SKIP_DC=1, bin 0 = 0x7F800000, others 0 -> peak_bin=1, peak_mag=0, above_cnt=0. Bin 2 = 0xC2C80000 (negative) -> treated as 0.
REQ-036 out_ready held 0 for 20 cycles after REPORT with mag_valid=1 -> mag_ready=0 and outputs stable. out_ready pulse -> next frame accepted from the following cycle.
REQ-037 Reset asserted after 30 bins, then a full frame -> a single result matching the post-reset frame only, frame_cnt=1.
REQ-038 Random mag_valid gaps over 3 frames, checked against a reference model -> all results match and frame_cnt=3.
